// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g} with a in bit 6.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_D0 = 7'b0000001;
  localparam logic [6:0] SEG_D1 = 7'b1001111;
  localparam logic [6:0] SEG_D2 = 7'b0010010;
  localparam logic [6:0] SEG_D3 = 7'b0000110;
  localparam logic [6:0] SEG_D4 = 7'b1001100;
  localparam logic [6:0] SEG_D5 = 7'b0100100;
  localparam logic [6:0] SEG_D6 = 7'b0100000;
  localparam logic [6:0] SEG_D7 = 7'b0001111;
  localparam logic [6:0] SEG_D8 = 7'b0000000;
  localparam logic [6:0] SEG_D9 = 7'b0000100;

  // Per-slot phase: anodes off during StBlank, one anode on during StDrive.
  typedef enum logic {StBlank, StDrive} scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_bcd_to_7seg_ca.sv
// Combinational BCD to common-anode 7-segment decoder.
// Ports:
//   bcd   - 4-bit BCD digit; codes 10-15 decode to all segments off
//   seg_n - active-low segments {a,b,c,d,e,f,g}
module bcd_to_7seg_ca
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0:    seg_n = SEG_D0;
      4'd1:    seg_n = SEG_D1;
      4'd2:    seg_n = SEG_D2;
      4'd3:    seg_n = SEG_D3;
      4'd4:    seg_n = SEG_D4;
      4'd5:    seg_n = SEG_D5;
      4'd6:    seg_n = SEG_D6;
      4'd7:    seg_n = SEG_D7;
      4'd8:    seg_n = SEG_D8;
      4'd9:    seg_n = SEG_D9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// A shadow buffer accepts new values at any time; they are moved into the
// active buffer only at a frame boundary so the display never tears.
// Ports:
//   clk, rst_n   - clock; synchronous active-low reset
//   load, ready  - load handshake; accepted when load && ready
//   bcd_in       - BCD digits, digit k in [4k+3:4k]
//   dp_in        - decimal points, 1 = lit
//   lz_blank_en  - live enable for leading-zero blanking
//   seg_n, dp_n  - active-low segments / decimal point (registered)
//   an_n         - active-low anode enables (registered, at most one low)
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  output logic                    ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;

  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] active_bcd_q, shadow_bcd_q;
  logic [NUM_DIGITS-1:0]   active_dp_q, shadow_dp_q;
  logic                    pending_q;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  slot_end, frame_end, accept;
  logic [3:0]            cur_bcd;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  // The slot counter spans the whole slot; the phase flips at fixed counts.
  assign slot_end  = (state_q == StDrive) && (cnt_q == SlotLast);
  assign frame_end = slot_end && (idx_q == IdxLast);
  assign ready     = ~pending_q;
  assign accept    = load && ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StBlank;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBlank: if (cnt_q == BlankLast) state_d = StDrive;
      StDrive: if (slot_end)           state_d = StBlank;
      default: state_d = StBlank;
    endcase
  end

  // Slot counter, digit index and double buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_bcd_q <= '0;
      active_dp_q  <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // accept requires !pending, commit requires pending: never both.
      if (frame_end && pending_q) begin
        active_bcd_q <= shadow_bcd_q;
        active_dp_q  <= shadow_dp_q;
        pending_q    <= 1'b0;
      end else if (accept) begin
        shadow_bcd_q <= bcd_in;
        shadow_dp_q  <= dp_in;
        pending_q    <= 1'b1;
      end
    end
  end

  assign cur_bcd = active_bcd_q[4*int'(idx_q) +: 4];

  bcd_to_7seg_ca u_dec (
    .bcd   (cur_bcd),
    .seg_n (dec_seg)
  );

  // lz_mask[k] is set when digit k and every higher digit are zero; digit 0 stays lit.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (active_bcd_q[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_run && (k != 0);
    end
  end

  // FSM outputs, registered below
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (state_q == StDrive) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = (lz_blank_en && lz_mask[idx_q]) ? SEG_BLANK : dec_seg;
      dp_d  = ~active_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          rst_n, load, ready, lz_blank_en, dp_n;
  logic [4*N-1:0] bcd_in;
  logic [N-1:0]  dp_in, an_n;
  logic [6:0]    seg_n;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .ready       (ready),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .lz_blank_en (lz_blank_en),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the whole display is a function of edges since reset (m),
  // the committed value and the live blanking enable.
  logic [6:0] tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int            m = 0;
  logic [4*N-1:0] act = '0, shd = '0;
  logic [N-1:0]  actdp = '0, shddp = '0;
  bit            pend = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, m, obs, exp);
    end
  endtask

  // One clock: predict outputs for the coming edge, advance the model, compare.
  task automatic tick();
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp;
    logic [3:0]   d;
    int           k, p;
    e_an  = '1;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (rst_n) begin
      p = m % R;
      k = (m / R) % N;
      if (p >= B) begin
        e_an  = ~(N'(1) << k);
        d     = act[4*k +: 4];
        e_seg = (d <= 9) ? tbl[d] : 7'h7F;
        if (lz_blank_en && k >= 1 && (act >> (4*k)) == 0) e_seg = 7'h7F;
        e_dp  = ~actdp[k];
      end
      if (((m + 1) % (N * R)) == 0 && pend) begin
        act   = shd;
        actdp = shddp;
        pend  = 0;
      end else if (load && !pend) begin
        shd   = bcd_in;
        shddp = dp_in;
        pend  = 1;
      end
      m++;
    end else begin
      m = 0; act = '0; actdp = '0; shd = '0; shddp = '0; pend = 0;
    end
    @(posedge clk);
    #1;
    chk("an_n", 7'(an_n), 7'(e_an));
    chk("seg_n", seg_n, e_seg);
    chk("dp_n", 7'(dp_n), 7'(e_dp));
    chk("ready", 7'(ready), 7'(!pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Pulse load for one cycle once the model says the shadow buffer is free.
  task automatic load_when_ready(input logic [4*N-1:0] v, input logic [N-1:0] dp);
    for (int i = 0; i < 100 && pend; i++) tick();
    if (pend) begin
      errors++;
      $display("FAIL ready_timeout: shadow still pending, required free within 100 cycles");
    end
    bcd_in = v;
    dp_in  = dp;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; lz_blank_en = 1'b0;

    // Plain scan of the reset value
    do_reset();
    run(40);

    // Load at cycle 5, ignored second load, then a later accepted one
    do_reset();
    run(4);
    bcd_in = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    tick();
    bcd_in = 16'h9999; dp_in = 4'b1111;
    tick();
    load = 1'b0;
    run(70);
    load_when_ready(16'h5678, 4'b0001);
    run(70);

    // Leading-zero blanking
    lz_blank_en = 1'b1;
    load_when_ready(16'h0070, 4'b1000);
    run(70);
    load_when_ready(16'h0000, 4'b0110);
    run(70);

    // Invalid BCD code
    lz_blank_en = 1'b0;
    load_when_ready(16'h00A5, 4'b0010);
    run(70);

    // Reset mid-DRIVE with a load pending
    load_when_ready(16'h4321, 4'b1111);
    for (int i = 0; i < 20 && (m % R) < B + 2; i++) tick();
    do_reset();
    run(40);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < N; j++)
        bcd_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      dp_in = N'($urandom);
      if ($urandom_range(0, 31) == 0) lz_blank_en = ~lz_blank_en;
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    load  = 1'b0;
    run(70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
